// File: rtl/stream_fifo.sv
// First-word-fall-through elastic buffer for the arbiter's 16-bit stb/ack output stream.
// Occupancy is tracked in an explicit counter; full/empty and both handshakes decode from it.
module stream_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int ADDR_BITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     input_z,
   input  logic                 input_z_stb,
   output logic                 input_z_ack,
   output logic [WIDTH-1:0]     output_q,
   output logic                 output_q_stb,
   input  logic                 output_q_ack,
   output logic [ADDR_BITS:0]   count,
   output logic                 full,
   output logic                 empty
);

   localparam logic [ADDR_BITS:0]   FULL_COUNT = (ADDR_BITS+1)'(DEPTH);
   localparam logic [ADDR_BITS:0]   CNT_ONE    = (ADDR_BITS+1)'(1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE    = (ADDR_BITS)'(1);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   logic                 wr_en;
   logic                 rd_en;

   // Status comes only from the registered count, so neither handshake depends on
   // the opposite side's inputs in the same cycle (no write-through, no bypass).
   assign full         = (count == FULL_COUNT);
   assign empty        = (count == '0);
   assign input_z_ack  = !full;
   assign output_q_stb = !empty;
   assign output_q     = empty ? '0 : mem[rd_ptr];

   assign wr_en = input_z_stb && !full;
   assign rd_en = output_q_ack && !empty;

   // NOTE: storage has no reset; pointers and count are reset, so stale words are unreachable.
   always_ff @(posedge clk) begin
      if (wr_en && rst)
         mem[wr_ptr] <= input_z;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: a queue model checked against the DUT on every falling
// edge, plus literal expectations at the key points of each scenario.
module tb_stream_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int ABITS = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [WIDTH-1:0]   input_z = '0;
   logic               input_z_stb = 1'b0;
   logic               input_z_ack;
   logic [WIDTH-1:0]   output_q;
   logic               output_q_stb;
   logic               output_q_ack = 1'b0;
   logic [ABITS:0]     count;
   logic               full;
   logic               empty;

   int n_checks = 0;
   int n_pass   = 0;

   logic [WIDTH-1:0] model_q[$];

   stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ABITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .input_z      (input_z),
      .input_z_stb  (input_z_stb),
      .input_z_ack  (input_z_ack),
      .output_q     (output_q),
      .output_q_stb (output_q_stb),
      .output_q_ack (output_q_ack),
      .count        (count),
      .full         (full),
      .empty        (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: a transfer happens on each side when stb is high and the occupancy allows it.
   always @(posedge clk) begin
      bit do_wr, do_rd;
      if (rst) begin
         do_wr = input_z_stb && (model_q.size() < DEPTH);
         do_rd = output_q_ack && (model_q.size() > 0);
         if (do_rd) void'(model_q.pop_front());
         if (do_wr) model_q.push_back(input_z);
      end
   end

   always @(negedge rst) model_q.delete();

   always @(negedge clk) begin
      int n;
      n = model_q.size();
      check("model_ack",   {31'd0, input_z_ack},  {31'd0, n < DEPTH});
      check("model_qstb",  {31'd0, output_q_stb}, {31'd0, n > 0});
      check("model_count", {28'd0, count},        n);
      check("model_full",  {31'd0, full},         {31'd0, n == DEPTH});
      check("model_empty", {31'd0, empty},        {31'd0, n == 0});
      check("model_q",     {16'd0, output_q},     (n > 0) ? {16'd0, model_q[0]} : 32'd0);
   end

   // Apply inputs, let one rising edge pass, return just after the next falling edge.
   task automatic step(input logic stb, input logic [WIDTH-1:0] data, input logic ack);
      input_z_stb  = stb;
      input_z      = data;
      output_q_ack = ack;
      @(negedge clk);
      #1;
   endtask

   logic [WIDTH-1:0] got[$];
   logic [WIDTH-1:0] exp_seq[$];

   initial begin
      #1 rst = 1'b0;
      // Reset held with both strobes toggling.
      for (int i = 0; i < 4; i++)
         step(i[0], 16'(i + 16'h0AA0), !i[0]);
      check("rst_ack",   {31'd0, input_z_ack},  32'd1);
      check("rst_qstb",  {31'd0, output_q_stb}, 32'd0);
      check("rst_count", {28'd0, count},        32'd0);
      check("rst_empty", {31'd0, empty},        32'd1);
      check("rst_q",     {16'd0, output_q},     32'd0);
      rst = 1'b1;

      // Single word latency.
      step(1'b1, 16'h1234, 1'b0);
      check("single_q",     {16'd0, output_q},     32'h1234);
      check("single_qstb",  {31'd0, output_q_stb}, 32'd1);
      check("single_count", {28'd0, count},        32'd1);
      step(1'b0, '0, 1'b1);
      check("single_empty", {31'd0, empty},        32'd1);

      // Fill to full, ninth word held off.
      for (int i = 1; i <= 8; i++)
         step(1'b1, 16'(i), 1'b0);
      check("fill_count", {28'd0, count},       32'd8);
      check("fill_full",  {31'd0, full},        32'd1);
      check("fill_ack",   {31'd0, input_z_ack}, 32'd0);
      step(1'b1, 16'h0009, 1'b0);
      step(1'b1, 16'h0009, 1'b0);
      check("hold_count", {28'd0, count},    32'd8);
      check("hold_q",     {16'd0, output_q}, 32'h0001);

      // Simultaneous read and write at full: only the read completes.
      step(1'b1, 16'h0009, 1'b1);
      check("simul_count", {28'd0, count},       32'd7);
      check("simul_q",     {16'd0, output_q},    32'h0002);
      check("simul_ack",   {31'd0, input_z_ack}, 32'd1);
      step(1'b1, 16'h0009, 1'b0);
      check("refill_count", {28'd0, count}, 32'd8);
      check("refill_full",  {31'd0, full},  32'd1);
      for (int i = 0; i < 8; i++)
         step(1'b0, '0, 1'b1);
      check("drain_empty", {31'd0, empty}, 32'd1);

      // Streaming with three words preloaded; occupancy must stay at 3.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'(16'h00A0 + i), 1'b0);
         exp_seq.push_back(16'(16'h00A0 + i));
      end
      for (int i = 0; i < 40; i++) begin
         exp_seq.push_back(16'(16'h0100 + i));
         got.push_back(output_q);
         step(1'b1, 16'(16'h0100 + i), 1'b1);
         check("stream_count", {28'd0, count}, 32'd3);
      end
      for (int i = 0; i < 40; i++)
         check("stream_order", {16'd0, got[i]}, {16'd0, exp_seq[i]});
      check("stream_tail", {16'd0, output_q}, 32'h0125);
      for (int i = 0; i < 3; i++)
         step(1'b0, '0, 1'b1);

      // Mid-burst reset pulse.
      for (int i = 0; i < 5; i++)
         step(1'b1, 16'(16'h0050 + i), 1'b0);
      check("burst_count", {28'd0, count}, 32'd5);
      input_z_stb = 1'b0;
      rst = 1'b0;
      #1;
      check("mrst_count", {28'd0, count},        32'd0);
      check("mrst_qstb",  {31'd0, output_q_stb}, 32'd0);
      check("mrst_empty", {31'd0, empty},        32'd1);
      #1 rst = 1'b1;
      step(1'b1, 16'hBEEF, 1'b0);
      check("post_q",     {16'd0, output_q}, 32'hBEEF);
      check("post_count", {28'd0, count},    32'd1);
      step(1'b0, '0, 1'b1);
      check("post_empty", {31'd0, empty}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
